// File: rtl/sprite_motion_engine_if.sv
// Game-master sprite load bus: one-cycle write strobe with initial position and per-move velocity.
interface sprite_motion_engine_if #(
  parameter int unsigned COORD_W = 11,
  parameter int unsigned DV_W    = 4
);
  logic                      sprite_write;
  logic signed [COORD_W-1:0] write_x;
  logic signed [COORD_W-1:0] write_y;
  logic signed [DV_W-1:0]    write_dx;
  logic signed [DV_W-1:0]    write_dy;

  modport master (output sprite_write, write_x, write_y, write_dx, write_dy);
  modport slave  (input  sprite_write, write_x, write_y, write_dx, write_dy);
endinterface

// File: rtl/sprite_motion_engine.sv
// Per-sprite position/motion engine: loads from the game master, steps once every MOVE_DIV
// frame ticks, reports on-screen visibility and a registered per-pixel hit.
module sprite_motion_engine #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned SPRITE_W = 8,
  parameter int unsigned SPRITE_H = 8,
  parameter int unsigned COORD_W  = 11,
  parameter int unsigned DV_W     = 4,
  parameter int unsigned MOVE_DIV = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  sprite_motion_engine_if.slave     wr_if,
  input  logic                      frame_tick,
  input  logic [COORD_W-1:0]        pixel_x,
  input  logic [COORD_W-1:0]        pixel_y,
  output logic signed [COORD_W-1:0] sprite_x,
  output logic signed [COORD_W-1:0] sprite_y,
  output logic                      sprite_within_screen,
  output logic                      sprite_hit
);

  localparam int unsigned CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int unsigned EXT_W = COORD_W + 1;
  localparam int unsigned PAD_W = COORD_W - DV_W;

  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic signed [COORD_W-1:0] X_MIN   = COORD_W'(0) - COORD_W'(SPRITE_W);
  localparam logic signed [COORD_W-1:0] Y_MIN   = COORD_W'(0) - COORD_W'(SPRITE_H);
  localparam logic signed [COORD_W-1:0] X_LIM   = COORD_W'(SCREEN_W);
  localparam logic signed [COORD_W-1:0] Y_LIM   = COORD_W'(SCREEN_H);
  localparam logic [EXT_W-1:0]          X_SPAN  = EXT_W'(SPRITE_W - 1);
  localparam logic [EXT_W-1:0]          Y_SPAN  = EXT_W'(SPRITE_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EXITED
  } state_e;

  state_e                    state_q;
  logic signed [COORD_W-1:0] x_q;
  logic signed [COORD_W-1:0] y_q;
  logic signed [DV_W-1:0]    dx_q;
  logic signed [DV_W-1:0]    dy_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      within_q;
  logic                      hit_q;

  logic                      vis_c;
  logic                      in_box_c;
  logic signed [COORD_W-1:0] x_step_c;
  logic signed [COORD_W-1:0] y_step_c;
  logic signed [EXT_W-1:0]   px_c;
  logic signed [EXT_W-1:0]   py_c;
  logic signed [EXT_W-1:0]   x0_c;
  logic signed [EXT_W-1:0]   y0_c;
  logic signed [EXT_W-1:0]   x1_c;
  logic signed [EXT_W-1:0]   y1_c;

  // Visibility, next step position and beam-inside-sprite test from the current registers.
  always_comb begin
    vis_c    = (x_q > X_MIN) && (x_q < X_LIM) && (y_q > Y_MIN) && (y_q < Y_LIM);
    x_step_c = $signed(x_q + {{PAD_W{dx_q[DV_W-1]}}, dx_q});
    y_step_c = $signed(y_q + {{PAD_W{dy_q[DV_W-1]}}, dy_q});
    // One extra bit keeps the far sprite edge from wrapping near the top of the range.
    px_c     = $signed({pixel_x[COORD_W-1], pixel_x});
    py_c     = $signed({pixel_y[COORD_W-1], pixel_y});
    x0_c     = $signed({x_q[COORD_W-1], x_q});
    y0_c     = $signed({y_q[COORD_W-1], y_q});
    x1_c     = $signed(x0_c + X_SPAN);
    y1_c     = $signed(y0_c + Y_SPAN);
    in_box_c = (px_c >= x0_c) && (px_c <= x1_c) && (py_c >= y0_c) && (py_c <= y1_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      cnt_q    <= '0;
      within_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      within_q <= (state_q == ST_ACTIVE) && vis_c;
      hit_q    <= (state_q == ST_ACTIVE) && in_box_c;

      // A load wins over everything, including a coincident frame tick.
      if (wr_if.sprite_write) begin
        x_q     <= wr_if.write_x;
        y_q     <= wr_if.write_y;
        dx_q    <= wr_if.write_dx;
        dy_q    <= wr_if.write_dy;
        cnt_q   <= '0;
        state_q <= ST_ACTIVE;
      end else if (state_q == ST_ACTIVE) begin
        if (!vis_c) begin
          state_q <= ST_EXITED;
        end else if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            x_q   <= x_step_c;
            y_q   <= y_step_c;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign sprite_x             = x_q;
  assign sprite_y             = y_q;
  assign sprite_within_screen = within_q;
  assign sprite_hit           = hit_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Bench for sprite_motion_engine: directed table, corner sequences and randomized traffic,
// with two instances (MOVE_DIV 1 and 2) checked against an integer reference model.
module tb_sprite_motion_engine;

  localparam int unsigned CW  = 11;
  localparam int unsigned VW  = 4;
  localparam int          FAR = 1000;

  logic clk = 1'b0;
  logic reset;
  logic frame_tick;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;

  logic signed [CW-1:0] sx1, sy1, sx2, sy2;
  logic win1, hit1, win2, hit2;

  int n_vec = 0;
  int n_bad = 0;

  sprite_motion_engine_if #(.COORD_W(CW), .DV_W(VW)) wif ();

  sprite_motion_engine #(.COORD_W(CW), .DV_W(VW), .MOVE_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .wr_if(wif.slave), .frame_tick(frame_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .sprite_x(sx1), .sprite_y(sy1),
    .sprite_within_screen(win1), .sprite_hit(hit1)
  );

  sprite_motion_engine #(.COORD_W(CW), .DV_W(VW), .MOVE_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .wr_if(wif.slave), .frame_tick(frame_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .sprite_x(sx2), .sprite_y(sy2),
    .sprite_within_screen(win2), .sprite_hit(hit2)
  );

  always #5 clk = ~clk;

  // Reference model: integer positions, a "live" flag and an accepted-tick count since load.
  int m_x[2], m_y[2], m_dx[2], m_dy[2], m_ticks[2];
  bit m_live[2], m_win[2], m_hit[2];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit on_screen(input int x, input int y);
    return (x > -8) && (x < 640) && (y > -8) && (y < 480);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0; m_ticks[i] = 0;
      m_live[i] = 0; m_win[i] = 0; m_hit[i] = 0;
    end
  endtask

  task automatic model_step();
    int px, py;
    bit nw, nh;
    px = int'(pixel_x);
    py = int'(pixel_y);
    for (int i = 0; i < 2; i++) begin
      nw = m_live[i] && on_screen(m_x[i], m_y[i]);
      nh = m_live[i] && px >= m_x[i] && px <= m_x[i] + 7 && py >= m_y[i] && py <= m_y[i] + 7;
      if (wif.sprite_write) begin
        m_x[i] = int'(wif.write_x);   m_y[i] = int'(wif.write_y);
        m_dx[i] = int'(wif.write_dx); m_dy[i] = int'(wif.write_dy);
        m_ticks[i] = 0; m_live[i] = 1;
      end else if (m_live[i]) begin
        if (!on_screen(m_x[i], m_y[i])) begin
          m_live[i] = 0;
        end else if (frame_tick) begin
          m_ticks[i]++;
          if (m_ticks[i] % div_of(i) == 0) begin
            m_x[i] += m_dx[i];
            m_y[i] += m_dy[i];
          end
        end
      end
      m_win[i] = nw;
      m_hit[i] = nh;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("d1.x", int'(sx1), m_x[0]);  chk("d1.y", int'(sy1), m_y[0]);
    chk("d1.win", int'(win1), int'(m_win[0])); chk("d1.hit", int'(hit1), int'(m_hit[0]));
    chk("d2.x", int'(sx2), m_x[1]);  chk("d2.y", int'(sy2), m_y[1]);
    chk("d2.win", int'(win2), int'(m_win[1])); chk("d2.hit", int'(hit2), int'(m_hit[1]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".d1.x"}, int'(sx1), 0);   chk({tag, ".d1.y"}, int'(sy1), 0);
    chk({tag, ".d1.win"}, int'(win1), 0); chk({tag, ".d1.hit"}, int'(hit1), 0);
    chk({tag, ".d2.x"}, int'(sx2), 0);   chk({tag, ".d2.y"}, int'(sy2), 0);
    chk({tag, ".d2.win"}, int'(win2), 0); chk({tag, ".d2.hit"}, int'(hit2), 0);
  endtask

  task automatic drive(input bit wr, input int x, input int y, input int dx, input int dy,
                       input bit tk, input int px, input int py);
    wif.sprite_write = wr;
    wif.write_x  = CW'(x);
    wif.write_y  = CW'(y);
    wif.write_dx = VW'(dx);
    wif.write_dy = VW'(dy);
    frame_tick   = tk;
    pixel_x      = CW'(px);
    pixel_y      = CW'(py);
  endtask

  task automatic idle(input bit tk);
    drive(1'b0, 0, 0, 0, 0, tk, FAR, FAR);
  endtask

  // Clock edge, model update with the inputs that edge sampled, then compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    bit wr; int x; int y; int dx; int dy; bit tk; int px; int py;
    int ex; int ey; bit ewin; bit ehit;
  } vec_t;

  function automatic vec_t mkv(input bit wr, input int x, input int y, input int dx, input int dy,
                               input bit tk, input int px, input int py,
                               input int ex, input int ey, input bit ewin, input bit ehit);
    vec_t v;
    v.wr = wr; v.x = x; v.y = y; v.dx = dx; v.dy = dy; v.tk = tk; v.px = px; v.py = py;
    v.ex = ex; v.ey = ey; v.ewin = ewin; v.ehit = ehit;
    return v;
  endfunction

  vec_t tbl[$];
  int   rx, ry, rdx, rdy, rpx, rpy, tgt;
  bit   rwr, rtk;

  initial begin
    // Expected values for the MOVE_DIV=1 instance after each edge.
    tbl.push_back(mkv(1, 100, 50, 2, -1, 0, FAR, FAR, 100, 50, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, FAR, FAR, 100, 50, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, FAR, FAR, 102, 49, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, FAR, FAR, 104, 48, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, FAR, FAR, 106, 47, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, FAR, FAR, 106, 47, 1, 0));
    tbl.push_back(mkv(1, 634, 10, 4, 0, 0, FAR, FAR, 634, 10, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, FAR, FAR, 638, 10, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, FAR, FAR, 642, 10, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, FAR, FAR, 642, 10, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, FAR, FAR, 642, 10, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, FAR, FAR, 642, 10, 0, 0));
    tbl.push_back(mkv(1, 10, 20, 0, 0, 0, FAR, FAR, 10, 20, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 17, 27, 10, 20, 1, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 18, 20, 10, 20, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 9, 20, 10, 20, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 10, 20, 10, 20, 1, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 17, 28, 10, 20, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 10, 19, 10, 20, 1, 0));

    reset = 1'b1;
    idle(1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].wr, tbl[k].x, tbl[k].y, tbl[k].dx, tbl[k].dy, tbl[k].tk, tbl[k].px, tbl[k].py);
      step();
      chk($sformatf("tbl%0d.x", k), int'(sx1), tbl[k].ex);
      chk($sformatf("tbl%0d.y", k), int'(sy1), tbl[k].ey);
      chk($sformatf("tbl%0d.win", k), int'(win1), int'(tbl[k].ewin));
      chk($sformatf("tbl%0d.hit", k), int'(hit1), int'(tbl[k].ehit));
    end

    // Load coincident with a frame tick: that tick must not count.
    drive(1, 0, 0, 1, 0, 1, FAR, FAR); step();
    chk("coin.d2.x0", int'(sx2), 0); chk("coin.d1.x0", int'(sx1), 0);
    idle(1'b1); step(); chk("coin.d2.x1", int'(sx2), 0); chk("coin.d1.x1", int'(sx1), 1);
    idle(1'b1); step(); chk("coin.d2.x2", int'(sx2), 1); chk("coin.d1.x2", int'(sx1), 2);
    idle(1'b1); step(); chk("coin.d2.x3", int'(sx2), 1); chk("coin.d1.x3", int'(sx1), 3);

    // Asynchronous reset in the middle of a cycle while moving.
    drive(1, 200, 200, 1, 1, 0, FAR, FAR); step();
    repeat (3) begin idle(1'b1); step(); end
    @(posedge clk);
    model_step();
    #3;
    reset = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin idle(1'b1); step(); end
    chk("postrst.d1.x", int'(sx1), 0); chk("postrst.d1.win", int'(win1), 0);
    drive(1, 5, 5, 0, 0, 0, FAR, FAR); step();
    chk("reload.d1.x", int'(sx1), 5); chk("reload.d2.x", int'(sx2), 5);
    chk("reload.d1.win0", int'(win1), 0);
    idle(1'b0); step();
    chk("reload.d1.win1", int'(win1), 1); chk("reload.d2.win1", int'(win2), 1);

    // Run off the right edge, then reload from EXITED and check the hit latency.
    drive(1, 630, 300, 7, 0, 0, FAR, FAR); step();
    repeat (8) begin idle(1'b1); step(); end
    chk("exit.d1.x", int'(sx1), 644); chk("exit.d1.win", int'(win1), 0);
    chk("exit.d2.x", int'(sx2), 644); chk("exit.d2.win", int'(win2), 0);
    drive(1, 300, 300, 0, 0, 0, 300, 300); step();
    chk("rearm.d1.hit0", int'(hit1), 0);
    drive(0, 0, 0, 0, 0, 0, 300, 300); step();
    chk("rearm.d1.hit1", int'(hit1), 1); chk("rearm.d2.hit1", int'(hit2), 1);

    // Randomized traffic, pixels biased towards one of the sprites to exercise hits.
    for (int n = 0; n < 3000; n++) begin
      rwr = ($urandom_range(0, 15) == 0);
      rtk = ($urandom_range(0, 2) == 0);
      rx  = int'($urandom_range(0, 530)) - 20;
      ry  = int'($urandom_range(0, 530)) - 20;
      rdx = int'($urandom_range(0, 14)) - 7;
      rdy = int'($urandom_range(0, 14)) - 7;
      tgt = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        rpx = m_x[tgt] + int'($urandom_range(0, 11)) - 2;
        rpy = m_y[tgt] + int'($urandom_range(0, 11)) - 2;
      end else begin
        rpx = int'($urandom_range(0, 700));
        rpy = int'($urandom_range(0, 520));
      end
      if (rpx < 0) rpx = 0;
      if (rpy < 0) rpy = 0;
      if (rpx > 1023) rpx = 1023;
      if (rpy > 1023) rpy = 1023;
      drive(rwr, rx, ry, rdx, rdy, rtk, rpx, rpy);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
